// File: rtl/block_nest_checker_if.sv
// Character-stream bus for block_nest_checker: byte input with valid, status outputs.
interface block_nest_checker_if #(
    parameter int unsigned DW = 4
);
    logic          in_valid;
    logic [7:0]    in;
    logic          result;
    logic [DW-1:0] depth;
    logic          error;
    logic [1:0]    err_code;

    modport master (
        output in_valid, in,
        input  result, depth, error, err_code
    );

    modport slave (
        input  in_valid, in,
        output result, depth, error, err_code
    );
endinterface

// File: rtl/block_nest_checker.sv
// Word-level begin/end and case/endcase nesting checker with a kind-tracking stack
// and a sticky first-error code.
module block_nest_checker #(
    parameter int unsigned DEPTH     = 8,
    parameter bit          CASE_SENS = 1'b0,
    parameter int unsigned DW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    block_nest_checker_if.slave  bus
);

    localparam int unsigned IW       = 4;
    localparam logic [7:0]  SPACE    = 8'h20;
    localparam logic [IW-1:0] IDX_MAX = IW'(8);

    localparam logic [1:0] K_BEGIN   = 2'd0;
    localparam logic [1:0] K_END     = 2'd1;
    localparam logic [1:0] K_CASE    = 2'd2;
    localparam logic [1:0] K_ENDCASE = 2'd3;

    localparam logic KIND_B = 1'b0;
    localparam logic KIND_C = 1'b1;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_EMPTY    = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_FULL     = 2'b11;

    function automatic logic [IW-1:0] kw_len(input logic [1:0] k);
        case (k)
            K_BEGIN:   kw_len = IW'(5);
            K_END:     kw_len = IW'(3);
            K_CASE:    kw_len = IW'(4);
            default:   kw_len = IW'(7);
        endcase
    endfunction

    function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [2:0] pos);
        kw_char = 8'h00;
        case (k)
            K_BEGIN: begin
                case (pos)
                    3'd0:    kw_char = "b";
                    3'd1:    kw_char = "e";
                    3'd2:    kw_char = "g";
                    3'd3:    kw_char = "i";
                    3'd4:    kw_char = "n";
                    default: kw_char = 8'h00;
                endcase
            end
            K_END: begin
                case (pos)
                    3'd0:    kw_char = "e";
                    3'd1:    kw_char = "n";
                    3'd2:    kw_char = "d";
                    default: kw_char = 8'h00;
                endcase
            end
            K_CASE: begin
                case (pos)
                    3'd0:    kw_char = "c";
                    3'd1:    kw_char = "a";
                    3'd2:    kw_char = "s";
                    3'd3:    kw_char = "e";
                    default: kw_char = 8'h00;
                endcase
            end
            default: begin
                case (pos)
                    3'd0:    kw_char = "e";
                    3'd1:    kw_char = "n";
                    3'd2:    kw_char = "d";
                    3'd3:    kw_char = "c";
                    3'd4:    kw_char = "a";
                    3'd5:    kw_char = "s";
                    3'd6:    kw_char = "e";
                    default: kw_char = 8'h00;
                endcase
            end
        endcase
    endfunction

    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       miss_q, miss_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [DEPTH-1:0] stack_q, stack_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;

    logic [7:0] ch;
    logic       top_kind;
    logic       commit;
    logic [3:0] hit;

    // Optional case folding of the incoming byte.
    always_comb begin
        ch = bus.in;
        if (!CASE_SENS && (bus.in >= "A") && (bus.in <= "Z")) begin
            ch = bus.in | 8'h20;
        end
    end

    always_comb begin
        top_kind = KIND_B;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top_kind = stack_q[i];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            hit[k] = !miss_q[k] && (idx_q == kw_len(2'(k)));
        end
    end

    assign commit = bus.in_valid && (bus.in == SPACE) && (idx_q != '0) && !error_q;

    // Word matcher and stack update.
    always_comb begin
        idx_d      = idx_q;
        miss_d     = miss_q;
        depth_d    = depth_q;
        stack_d    = stack_q;
        error_d    = error_q;
        err_code_d = err_code_q;

        if (bus.in_valid) begin
            if (bus.in == SPACE) begin
                idx_d  = '0;
                miss_d = '0;
            end else begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if ((idx_q >= kw_len(2'(k))) || (ch != kw_char(2'(k), idx_q[2:0]))) begin
                        miss_d[k] = 1'b1;
                    end
                end
                if (idx_q != IDX_MAX) idx_d = idx_q + IW'(1);
            end
        end

        if (commit) begin
            if (hit[K_BEGIN] || hit[K_CASE]) begin
                if (depth_q == DW'(DEPTH)) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_FULL;
                end else begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (depth_q == DW'(i)) stack_d[i] = hit[K_CASE] ? KIND_C : KIND_B;
                    end
                    depth_d = depth_q + DW'(1);
                end
            end else if (hit[K_END] || hit[K_ENDCASE]) begin
                if (depth_q == '0) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_EMPTY;
                end else if (top_kind != (hit[K_ENDCASE] ? KIND_C : KIND_B)) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_MISMATCH;
                end else begin
                    depth_d = depth_q - DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            miss_q     <= '0;
            depth_q    <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            idx_q      <= idx_d;
            miss_q     <= miss_d;
            depth_q    <= depth_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    // Stack contents are don't-care after reset; depth_q alone defines validity.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.depth    = depth_q;
    assign bus.error    = error_q;
    assign bus.err_code = err_code_q;
    assign bus.result   = !error_q && (depth_q == '0);

endmodule
